dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Shares the single data-memory RAM between two requesters: the pipeline memory stage (CPU, port 0) and the program-loader/DMA engine (DMA, port 1). It sits between the memory stage and the `ram` instance. It performs round-robin arbitration, with an optional bounded DMA burst lock. It registers read responses back to the winning requester and produces the memory-stage stall.

Parameters:
- WIDTH, 32, data and address width.
- MAX_BURST, 4, maximum consecutive cycles DMA may hold the RAM under lock (≥1).

Ports:
- clk  input  1  system clock; one clock domain.
- rst  input  1  synchronous, active-high reset.
- cpu_req_valid  input  1  CPU access request.
- cpu_req_ready  output  1  CPU request accepted this cycle.
- cpu_addr  input  WIDTH  CPU byte address.
- cpu_wdata  input  WIDTH  CPU store data.
- cpu_we  input  1  CPU write (1) / read (0).
- cpu_byte_en  input  4  CPU store byte lanes.
- cpu_rsp_valid  output  1  CPU read data valid.
- cpu_rdata  output  WIDTH  CPU read data.
- dma_req_valid, dma_req_ready, dma_addr, dma_wdata, dma_we, dma_byte_en, dma_rsp_valid, dma_rdata  same widths/directions/meaning as the cpu_ equivalents.
- dma_lock  input  1  DMA requests burst ownership.
- mem_addr  output  WIDTH  RAM address.
- mem_write_data  output  WIDTH  RAM write data.
- mem_write_enable  output  1  RAM write strobe.
- mem_byte_en  output  4  RAM byte enables.
- mem_read_data  input  WIDTH  RAM combinational read word.
- stall_m  output  1  equals cpu_req_valid & ~cpu_req_ready.

Behaviour:
- **Throughput and grant timing**
  - At most one grant per cycle.
  - The grant is combinational from the current state and the valids.
  - req_ready is asserted only for the granted requester.
- **States**
  - CPU_PRI (reset state).
  - DMA_PRI.
  - DMA_LOCK.
- **CPU_PRI / DMA_PRI**
  - The favoured requester wins if valid; otherwise the other requester wins if valid.
  - After a CPU grant, the next state is DMA_PRI.
  - After a DMA grant with dma_lock=0, the next state is CPU_PRI.
  - After a DMA grant with dma_lock=1, the next state is DMA_LOCK and lock_cnt is set to 1.
  - With no grant, the state is unchanged.
- **DMA_LOCK**
  - The CPU is never granted.
  - DMA is granted whenever dma_req_valid=1.
  - lock_cnt increments every cycle spent in the state, whether or not a beat occurs.
  - Exit to CPU_PRI when dma_lock=0, or at the end of the cycle in which lock_cnt reaches MAX_BURST.
  - Total DMA ownership is therefore ≤ MAX_BURST cycles, including the entry cycle.
- **RAM drive**
  - mem_addr, mem_write_data and mem_byte_en come from the granted requester.
  - mem_write_enable = granted & we.
  - mem_byte_en is forced to 4'b0000 unless mem_write_enable=1.
  - With no grant, all mem_ outputs are 0.
- **Read response**
  - On a granted read, mem_read_data is registered into that requester's rdata.
  - rsp_valid is pulsed for exactly one cycle, on the cycle after the grant (latency 1).
  - Writes produce no response.
  - rdata holds its last value when rsp_valid=0.
- **Write-then-read**
  - The RAM write is synchronous.
  - A read granted in the cycle after a write to the same address returns the new data; no bypass is required.
- **Reset**
  - While rst=1: both req_ready=0, mem_write_enable=0, mem_byte_en=0.
  - Next state is CPU_PRI, lock_cnt=0, both rsp_valid=0, both rdata=0.
  - A reset in DMA_LOCK abandons the burst; a read granted in the cycle before reset yields no response.
- **Stall**
  - stall_m is purely combinational.
  - The CPU must hold its request stable while stall_m=1.

Decomposition:
- Package dmem_arb_pkg contains:
  - arb_state_e (CPU_PRI, DMA_PRI, DMA_LOCK).
  - req_id_e (REQ_CPU, REQ_DMA).
  - the constant BYTE_LANES=4.
- One sub-module, rr_arb2: a two-way round-robin grant given the valids and a priority bit.
- The FSM, lock counter, mux and response registers live in dmem_arbiter.

Test Plan:
- **CPU only:** CPU writes 0xDEADBEEF to 0x10 with byte_en 1111, then reads 0x10. Expect mem_write_enable=1 in cycle 0, cpu_rsp_valid=1 with cpu_rdata=0xDEADBEEF in cycle 2, and stall_m=0 throughout.
- **Contention, no lock:** both requesters valid for 4 cycles from reset. Expect grants CPU, DMA, CPU, DMA, and stall_m=1 only in cycles 1 and 3.
- **Lock burst (MAX_BURST=4):** dma_lock=1, DMA and CPU valid continuously, DMA granted first. Expect DMA granted 4 consecutive cycles, CPU granted on the 5th, and stall_m high for the 4 DMA cycles.
- **Early lock release:** dma_lock drops after 2 DMA beats. Expect CPU granted in the 3rd cycle.
- **Reset mid-lock:** assert rst in the 2nd lock cycle while a DMA read is pending. Expect no mem_write_enable, no dma_rsp_valid, and a CPU grant in the first cycle after rst falls.
- **Byte-enable gating:** DMA read with dma_byte_en=1111. Expect mem_byte_en=0000 and mem_write_enable=0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
//------------------------------------------------------------------------------
// Module      : dmem_arb_pkg
// Description : Shared types and constants for the data-memory arbiter.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package dmem_arb_pkg;

    typedef enum logic [1:0] {
        CPU_PRI  = 2'd0,
        DMA_PRI  = 2'd1,
        DMA_LOCK = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DMA = 1'b1
    } req_id_e;

    localparam int BYTE_LANES = 4;

endpackage

`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
//------------------------------------------------------------------------------
// Module      : dmem_arbiter_if
// Description : Requester, RAM and stall signals of the data-memory arbiter.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface dmem_arbiter_if #(
    parameter int WIDTH = 32
);
    import dmem_arb_pkg::*;

    logic                  cpu_req_valid;
    logic                  cpu_req_ready;
    logic [WIDTH-1:0]      cpu_addr;
    logic [WIDTH-1:0]      cpu_wdata;
    logic                  cpu_we;
    logic [BYTE_LANES-1:0] cpu_byte_en;
    logic                  cpu_rsp_valid;
    logic [WIDTH-1:0]      cpu_rdata;

    logic                  dma_req_valid;
    logic                  dma_req_ready;
    logic [WIDTH-1:0]      dma_addr;
    logic [WIDTH-1:0]      dma_wdata;
    logic                  dma_we;
    logic [BYTE_LANES-1:0] dma_byte_en;
    logic                  dma_rsp_valid;
    logic [WIDTH-1:0]      dma_rdata;
    logic                  dma_lock;

    logic [WIDTH-1:0]      mem_addr;
    logic [WIDTH-1:0]      mem_write_data;
    logic                  mem_write_enable;
    logic [BYTE_LANES-1:0] mem_byte_en;
    logic [WIDTH-1:0]      mem_read_data;

    logic                  stall_m;

    // Requesters and RAM model side
    modport master (
        output cpu_req_valid, cpu_addr, cpu_wdata, cpu_we, cpu_byte_en,
        input  cpu_req_ready, cpu_rsp_valid, cpu_rdata,
        output dma_req_valid, dma_addr, dma_wdata, dma_we, dma_byte_en, dma_lock,
        input  dma_req_ready, dma_rsp_valid, dma_rdata,
        input  mem_addr, mem_write_data, mem_write_enable, mem_byte_en,
        output mem_read_data,
        input  stall_m
    );

    // Arbiter side
    modport slave (
        input  cpu_req_valid, cpu_addr, cpu_wdata, cpu_we, cpu_byte_en,
        output cpu_req_ready, cpu_rsp_valid, cpu_rdata,
        input  dma_req_valid, dma_addr, dma_wdata, dma_we, dma_byte_en, dma_lock,
        output dma_req_ready, dma_rsp_valid, dma_rdata,
        output mem_addr, mem_write_data, mem_write_enable, mem_byte_en,
        input  mem_read_data,
        output stall_m
    );

endinterface

`default_nettype wire

// File: rtl/dmem_arbiter_rr_arb2.sv
//------------------------------------------------------------------------------
// Module      : rr_arb2
// Description : Two-way grant; the favoured requester wins ties.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rr_arb2
    import dmem_arb_pkg::*;
(
    input  wire logic    [1:0] i_valid,
    input  wire req_id_e       i_favour,
    output logic         [1:0] o_grant
);

    logic w_fav_dma;

    assign w_fav_dma  = (i_favour == REQ_DMA);
    assign o_grant[0] = i_valid[0] & (~w_fav_dma | ~i_valid[1]);
    assign o_grant[1] = i_valid[1] & ( w_fav_dma | ~i_valid[0]);

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
//------------------------------------------------------------------------------
// Module      : dmem_arbiter
// Description : Round-robin CPU/DMA arbiter for the data RAM with DMA burst lock.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 4
) (
    input  wire logic     clk,
    input  wire logic     rst,
    dmem_arbiter_if.slave bus
);

    localparam logic [1:0] c_ST_CPU_PRI  = CPU_PRI;
    localparam logic [1:0] c_ST_DMA_PRI  = DMA_PRI;
    localparam logic [1:0] c_ST_DMA_LOCK = DMA_LOCK;
    localparam int         c_CNT_W       = $clog2(MAX_BURST + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(MAX_BURST);
    // A one-cycle burst is just the entry grant, so the lock state is never entered.
    localparam bit         c_LOCK_EN     = (MAX_BURST > 1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_lock_cnt;
    logic [c_CNT_W-1:0] w_lock_cnt_nxt;

    logic [1:0]         w_rr_grant;
    req_id_e            w_favour;
    logic               w_gnt_cpu;
    logic               w_gnt_dma;

    logic               r_cpu_rsp_valid;
    logic               r_dma_rsp_valid;
    logic [WIDTH-1:0]   r_cpu_rdata;
    logic [WIDTH-1:0]   r_dma_rdata;

    assign w_favour = (r_state == c_ST_DMA_PRI) ? REQ_DMA : REQ_CPU;

    rr_arb2 u_rr_arb2 (
        .i_valid  ({bus.dma_req_valid, bus.cpu_req_valid}),
        .i_favour (w_favour),
        .o_grant  (w_rr_grant)
    );

    always_comb begin
        w_gnt_cpu = 1'b0;
        w_gnt_dma = 1'b0;
        if (!rst) begin
            if (r_state == c_ST_DMA_LOCK) begin
                w_gnt_dma = bus.dma_req_valid;
            end else begin
                w_gnt_cpu = w_rr_grant[0];
                w_gnt_dma = w_rr_grant[1];
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_lock_cnt_nxt = r_lock_cnt;
        case (r_state)
            c_ST_DMA_LOCK: begin
                // Counts lock cycles regardless of whether a beat was taken.
                w_lock_cnt_nxt = r_lock_cnt + 1'b1;
                if (!bus.dma_lock || (w_lock_cnt_nxt == c_CNT_MAX)) begin
                    w_state_nxt    = c_ST_CPU_PRI;
                    w_lock_cnt_nxt = '0;
                end
            end
            default: begin
                if (w_gnt_cpu) begin
                    w_state_nxt = c_ST_DMA_PRI;
                end else if (w_gnt_dma) begin
                    if (bus.dma_lock && c_LOCK_EN) begin
                        w_state_nxt    = c_ST_DMA_LOCK;
                        w_lock_cnt_nxt = c_CNT_W'(1);
                    end else begin
                        w_state_nxt = c_ST_CPU_PRI;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= c_ST_CPU_PRI;
            r_lock_cnt      <= '0;
            r_cpu_rsp_valid <= 1'b0;
            r_dma_rsp_valid <= 1'b0;
            r_cpu_rdata     <= '0;
            r_dma_rdata     <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_lock_cnt      <= w_lock_cnt_nxt;
            r_cpu_rsp_valid <= w_gnt_cpu & ~bus.cpu_we;
            r_dma_rsp_valid <= w_gnt_dma & ~bus.dma_we;
            if (w_gnt_cpu && !bus.cpu_we) begin
                r_cpu_rdata <= bus.mem_read_data;
            end
            if (w_gnt_dma && !bus.dma_we) begin
                r_dma_rdata <= bus.mem_read_data;
            end
        end
    end

    always_comb begin
        bus.mem_addr         = '0;
        bus.mem_write_data   = '0;
        bus.mem_write_enable = 1'b0;
        bus.mem_byte_en      = '0;
        if (w_gnt_cpu) begin
            bus.mem_addr         = bus.cpu_addr;
            bus.mem_write_data   = bus.cpu_wdata;
            bus.mem_write_enable = bus.cpu_we;
            bus.mem_byte_en      = bus.cpu_we ? bus.cpu_byte_en : '0;
        end else if (w_gnt_dma) begin
            bus.mem_addr         = bus.dma_addr;
            bus.mem_write_data   = bus.dma_wdata;
            bus.mem_write_enable = bus.dma_we;
            bus.mem_byte_en      = bus.dma_we ? bus.dma_byte_en : '0;
        end
    end

    assign bus.cpu_req_ready = w_gnt_cpu;
    assign bus.dma_req_ready = w_gnt_dma;
    // A read granted just before reset must not surface during the reset cycle.
    assign bus.cpu_rsp_valid = r_cpu_rsp_valid & ~rst;
    assign bus.dma_rsp_valid = r_dma_rsp_valid & ~rst;
    assign bus.cpu_rdata     = r_cpu_rdata;
    assign bus.dma_rdata     = r_dma_rdata;
    assign bus.stall_m       = bus.cpu_req_valid & ~w_gnt_cpu;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
//------------------------------------------------------------------------------
// Module      : tb_dmem_arbiter
// Description : Directed bench for dmem_arbiter with a read-response scoreboard.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_dmem_arbiter;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_errors;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        cpu_q[$];
    exp_t        dma_q[$];
    logic [31:0] ram    [0:63];
    logic [31:0] shadow [0:63];

    dmem_arbiter_if #(.WIDTH(32)) bus ();

    dmem_arbiter #(
        .WIDTH     (32),
        .MAX_BURST (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (bus.mem_write_enable) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_byte_en[b]) ram[bus.mem_addr[7:2]][8*b +: 8] <= bus.mem_write_data[8*b +: 8];
            end
        end
    end
    assign bus.mem_read_data = ram[bus.mem_addr[7:2]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cpu_q.size() > 0 && cpu_q[0].due == cyc) begin
            check("cpu_rsp_valid", {31'd0, bus.cpu_rsp_valid}, 32'd1);
            check("cpu_rdata", bus.cpu_rdata, cpu_q[0].data);
            void'(cpu_q.pop_front());
        end else if (bus.cpu_rsp_valid) begin
            check("cpu_rsp_spurious", {31'd0, bus.cpu_rsp_valid}, 32'd0);
        end
        if (dma_q.size() > 0 && dma_q[0].due == cyc) begin
            check("dma_rsp_valid", {31'd0, bus.dma_rsp_valid}, 32'd1);
            check("dma_rdata", bus.dma_rdata, dma_q[0].data);
            void'(dma_q.pop_front());
        end else if (bus.dma_rsp_valid) begin
            check("dma_rsp_spurious", {31'd0, bus.dma_rsp_valid}, 32'd0);
        end
    end

    task automatic set_cpu(input bit v, input bit we, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] be);
        bus.cpu_req_valid = v;
        bus.cpu_we        = we;
        bus.cpu_addr      = a;
        bus.cpu_wdata     = wd;
        bus.cpu_byte_en   = be;
    endtask

    task automatic set_dma(input bit v, input bit we, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] be, input bit lock);
        bus.dma_req_valid = v;
        bus.dma_we        = we;
        bus.dma_addr      = a;
        bus.dma_wdata     = wd;
        bus.dma_byte_en   = be;
        bus.dma_lock      = lock;
    endtask

    // Checks one cycle against the expected grant, then advances to the next cycle.
    task automatic step(input bit gc, input bit gd, input bit st, input bit push);
        logic [31:0] e_addr;
        logic [31:0] e_wd;
        logic        e_we;
        logic [3:0]  e_be;
        exp_t        e;
        #3;
        check("cpu_req_ready", {31'd0, bus.cpu_req_ready}, {31'd0, gc});
        check("dma_req_ready", {31'd0, bus.dma_req_ready}, {31'd0, gd});
        check("stall_m", {31'd0, bus.stall_m}, {31'd0, st});
        e_addr = '0; e_wd = '0; e_we = 1'b0; e_be = '0;
        if (gc) begin
            e_addr = bus.cpu_addr; e_wd = bus.cpu_wdata; e_we = bus.cpu_we;
            e_be   = bus.cpu_we ? bus.cpu_byte_en : 4'b0000;
        end else if (gd) begin
            e_addr = bus.dma_addr; e_wd = bus.dma_wdata; e_we = bus.dma_we;
            e_be   = bus.dma_we ? bus.dma_byte_en : 4'b0000;
        end
        check("mem_addr", bus.mem_addr, e_addr);
        check("mem_write_data", bus.mem_write_data, e_wd);
        check("mem_write_enable", {31'd0, bus.mem_write_enable}, {31'd0, e_we});
        check("mem_byte_en", {28'd0, bus.mem_byte_en}, {28'd0, e_be});
        if (e_we) begin
            for (int b = 0; b < 4; b++) begin
                if (e_be[b]) shadow[e_addr[7:2]][8*b +: 8] = e_wd[8*b +: 8];
            end
        end else if ((gc || gd) && push) begin
            e.data = shadow[e_addr[7:2]];
            e.due  = cyc + 1;
            if (gc) cpu_q.push_back(e);
            else    dma_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        set_cpu(1'b0, 1'b0, 32'd0, 32'd0, 4'b0000);
        set_dma(1'b0, 1'b0, 32'd0, 32'd0, 4'b0000, 1'b0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        cyc = 0; n_checks = 0; n_errors = 0;
        for (int i = 0; i < 64; i++) begin
            ram[i]    = 32'd0;
            shadow[i] = 32'd0;
        end
        rst = 1'b1;
        idle_all();
        @(posedge clk);
        #1;

        // Reset: requests present but nothing granted
        set_cpu(1'b1, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'b1111);
        set_dma(1'b1, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'b1111, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
        check("rst_dma_rdata", bus.dma_rdata, 32'd0);
        rst = 1'b0;
        idle_all();

        // CPU only: write then read back
        set_cpu(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'b1111);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        set_cpu(1'b1, 1'b0, 32'h10, 32'd0, 4'b1111);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        idle_all();
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Contention without lock, from reset
        pulse_reset();
        set_cpu(1'b1, 1'b0, 32'h10, 32'd0, 4'b0000);
        set_dma(1'b1, 1'b1, 32'h20, 32'h1234_5678, 4'b0011, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        set_dma(1'b1, 1'b0, 32'h20, 32'd0, 4'b0000, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        idle_all();
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Full lock burst: one CPU grant first so DMA is favoured
        set_cpu(1'b1, 1'b0, 32'h10, 32'd0, 4'b0000);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        set_dma(1'b1, 1'b0, 32'h20, 32'd0, 4'b0000, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);

        // Early lock release on the second beat
        set_dma(1'b1, 1'b0, 32'h20, 32'd0, 4'b0000, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        set_dma(1'b1, 1'b0, 32'h20, 32'd0, 4'b0000, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);

        // Byte-enable gating on a DMA read
        set_cpu(1'b0, 1'b0, 32'd0, 32'd0, 4'b0000);
        set_dma(1'b1, 1'b0, 32'h10, 32'd0, 4'b1111, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        idle_all();
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of a lock burst with a DMA read pending
        set_cpu(1'b1, 1'b0, 32'h20, 32'd0, 4'b0000);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        set_dma(1'b1, 1'b0, 32'h10, 32'd0, 4'b0000, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b1, 1'b0);
        rst = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b1);
        idle_all();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1);

        check("cpu_q_drained", cpu_q.size(), 32'd0);
        check("dma_q_drained", dma_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
